// File: rtl/gpu_pixel_writer.sv
// Pixel sink: converts (x, y, rgb) pixels into linear framebuffer writes through a small FIFO.
// Optional clipping of off-screen pixels is enabled by defining PIXEL_WRITER_CLIP_EN.
module gpu_pixel_writer #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int ADDR_BITS    = 19,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  input  logic [WIDTH_BITS-1:0]     x_i,
  input  logic [HEIGHT_BITS-1:0]    y_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  output logic                      mem_req_o,
  output logic [ADDR_BITS-1:0]      mem_addr_o,
  output logic [3*CHANNEL_BITS-1:0] mem_data_o,
  input  logic                      mem_ack_i,
  output logic                      idle_o,
  output logic [15:0]               drop_cnt_o
);

  localparam int DATA_BITS  = 3 * CHANNEL_BITS;
  localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
  localparam int PTR_BITS   = $clog2(DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] WIDTH_A  = ADDR_BITS'(WIDTH);
  localparam logic [CNT_BITS-1:0]  FULL_CNT = CNT_BITS'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      (longint'(1) << ADDR_BITS) < longint'(WIDTH) * longint'(HEIGHT)) begin : g_bad_params
    $error("gpu_pixel_writer: illegal DEPTH/ADDR_BITS for the framebuffer size");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state_q, state_d;
  logic [ENTRY_BITS-1:0] fifo_mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]   count;
  logic                  full, empty;
  logic                  accept, push, pop, clip;
  logic [ADDR_BITS-1:0]  pix_addr;
  logic [ENTRY_BITS-1:0] head_entry;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign pix_ready_o = !full;
  assign accept      = pix_valid_i && pix_ready_o;
  assign push        = accept && !clip;
  assign pix_addr    = ADDR_BITS'(y_i) * WIDTH_A + ADDR_BITS'(x_i);
  assign head_entry  = fifo_mem[rd_ptr];

  assign mem_req_o = (state_q == REQ);
  assign idle_o    = (state_q == IDLE) && empty;

`ifdef PIXEL_WRITER_CLIP_EN
  logic [15:0] drop_cnt_q;

  assign clip = (32'(x_i) >= WIDTH) || (32'(y_i) >= HEIGHT);

  // Clipped pixels still complete the handshake; they only bump this saturating counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_cnt_q <= '0;
    end else if (accept && clip && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign clip       = 1'b0;
  assign drop_cnt_o = 16'h0000;
`endif

  // Storage is not reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, r_i, g_i, b_i};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pop loads the output registers, so a write is held stable until acknowledged.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        {mem_addr_o, mem_data_o} <= head_entry;
      end
    end
  end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Pixel sink for the GPU drawing primitives: accepts one (x, y, r, g, b) pixel per cycle from a drawing engine and commits it to the framebuffer memory. Each pixel is converted to a linear framebuffer address and packed into a single RGB word. Pixels are buffered in a small FIFO so the drawing engine can keep running while the memory port stalls. The block sits between the primitive generators (rectangle fill, line, etc.) and the SRAM/framebuffer controller.

## Interface

Parameters:
- WIDTH_BITS, 10: x coordinate width
- HEIGHT_BITS, 9: y coordinate width
- CHANNEL_BITS, 8: per-channel color width
- WIDTH, 640: framebuffer width in pixels
- HEIGHT, 480: framebuffer height in pixels
- ADDR_BITS, 19: memory address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT
- DEPTH, 4: FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock, all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- pix_valid_i  in  1  pixel present on x_i/y_i/r_i/g_i/b_i
- pix_ready_o  out  1  block can accept a pixel this cycle
- x_i  in  WIDTH_BITS  pixel column
- y_i  in  HEIGHT_BITS  pixel row
- r_i, g_i, b_i  in  CHANNEL_BITS each  pixel color
- mem_req_o  out  1  write request to framebuffer
- mem_addr_o  out  ADDR_BITS  write address
- mem_data_o  out  3*CHANNEL_BITS  write data, {r,g,b}, r in MSBs
- mem_ack_i  in  1  framebuffer accepted the current write
- idle_o  out  1  FIFO empty and no write outstanding
- drop_cnt_o  out  16  clipped-pixel count

## Operation

- Transfer occurs on a rising edge where pix_valid_i && pix_ready_o. pix_ready_o = !full (combinational from FIFO count only; no dependence on pix_valid_i or mem_ack_i).
- At push: addr = y_i*WIDTH + x_i, computed at ADDR_BITS width, modulo 2^ADDR_BITS; data = {r_i,g_i,b_i}. Entry {addr,data} written at FIFO tail.
- Full FIFO blocks push even if a pop occurs the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.
- Write FSM, two states:
  - IDLE: mem_req_o=0. If FIFO non-empty: pop head into mem_addr_o/mem_data_o registers, go REQ.
  - REQ: mem_req_o=1; addr/data held stable until mem_ack_i=1 sampled. On ack: if FIFO non-empty, pop next entry, stay REQ (back-to-back, req stays high); else go IDLE.
- mem_ack_i ignored in IDLE.
- idle_o = (state==IDLE) && FIFO empty.
- No bypass: an empty FIFO still costs one cycle.

## Timing

- Reset values: mem_req_o=0, mem_addr_o=0, mem_data_o=0, drop_cnt_o=0, idle_o=1, pix_ready_o=1, FIFO count 0, state IDLE.
- Latency: pixel accepted at edge E0 -> mem_req_o high after E1 with that pixel's address/data.
- Throughput: one write per cycle while mem_ack_i held high and FIFO non-empty.
- Reset mid-operation: FIFO contents discarded, mem_req_o dropped immediately (asynchronous), outstanding write abandoned.

## Configuration

- PIXEL_WRITER_CLIP_EN defined: a pixel with x_i >= WIDTH or y_i >= HEIGHT completes the handshake (consumes pix_ready_o) but is not pushed. drop_cnt_o increments by 1, saturating at 16'hFFFF.
- Not defined: every pixel is pushed, with the address wrapping modulo 2^ADDR_BITS, and drop_cnt_o is tied to 0.

## Test plan

- Single pixel x=3, y=2, rgb=FF/80/01, mem_ack_i held 1 -> mem_req_o pulses 1 cycle, 2 edges after accept, with addr=1283 and data=24'hFF8001; idle_o returns to 1.
- Burst of 6 pixels (0,0)..(5,0) with mem_ack_i=0 -> pix_ready_o drops after 5 accepts (4 FIFO + 1 in REQ). mem_addr_o holds 0 stably. Raising ack drains addrs 0..5 in order on consecutive cycles.
- Ack stall: ack low 10 cycles, then one pulse -> exactly one write retired; addr/data unchanged during the stall.
- Clip (PIXEL_WRITER_CLIP_EN defined): pixels (640,0), (0,480), (639,479) -> one write, addr=307199; drop_cnt_o=2. Without the macro: three writes, with the first addr=640.
- Reset asserted while REQ with 3 entries queued -> mem_req_o=0 immediately, idle_o=1. Post-reset a new pixel (1,0) produces a single write to addr=1.
- Push and pop the same cycle with 2 entries queued -> count stays 2 and pix_ready_o remains 1.
